// File: rtl/btc_job_master.sv
// btc_job_master
//   Wishbone master that feeds a 20-word block header into the hasher core,
//   writes CONFIG, kicks START, polls STATUS until done, then reads NONCE and
//   presents the outcome on a valid/ready result port.
//
//   Optional feature (macro BTC_JOB_MASTER_TIMEOUT_EN): abort a transfer that
//   has been outstanding TIMEOUT_CYCLES cycles, exactly as if wbErr was seen.
//   With the macro undefined, transfers wait for wbAck/wbErr forever.
//
// Ports
//   clk, wbRst            single rising-edge clock, synchronous active-high reset
//   wbAddr/Sel/We/WData   registered Wishbone request (Sel = 4'hF while in a cycle)
//   wbCycle, wbStrobe     registered, always equal
//   wbRData, wbAck, wbErr slave response (wbErr wins over wbAck)
//   jobWord, jobValid     header word stream; jobReady pulses with the write's wbAck
//   cfgUseNonceIn,
//   cfgOneshot            CONFIG bits 0/1, sampled when the CONFIG write launches
//   resValid, resReady    result handshake
//   resNonce, resFound,
//   resErr                result payload, stable while resValid is high

module btc_job_master #(
  parameter int POLL_GAP       = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        wbRst,
  output logic [7:0]  wbAddr,
  output logic [3:0]  wbSel,
  output logic        wbWe,
  output logic [31:0] wbWData,
  output logic        wbCycle,
  output logic        wbStrobe,
  input  logic [31:0] wbRData,
  input  logic        wbAck,
  input  logic        wbErr,
  input  logic [31:0] jobWord,
  input  logic        jobValid,
  output logic        jobReady,
  input  logic        cfgUseNonceIn,
  input  logic        cfgOneshot,
  output logic        resValid,
  input  logic        resReady,
  output logic [31:0] resNonce,
  output logic        resFound,
  output logic        resErr
);

  localparam logic [2:0] S_LOAD   = 3'd0;
  localparam logic [2:0] S_CFG    = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_POLL   = 3'd4;
  localparam logic [2:0] S_NONCE  = 3'd5;
  localparam logic [2:0] S_RESULT = 3'd6;

  localparam logic [7:0] A_CONFIG = 8'h00;
  localparam logic [7:0] A_HDR0   = 8'h04;
  localparam logic [7:0] A_NONCE  = 8'h50;
  localparam logic [7:0] A_STATUS = 8'h54;

  // A zero gap still idles one cycle so the poll loop never degenerates.
  localparam int              GAP_N    = (POLL_GAP < 1) ? 1 : POLL_GAP;
  localparam int              GW       = $clog2(GAP_N + 1);
  localparam logic [GW-1:0]   GAP_LOAD = GW'(GAP_N - 1);

  logic [2:0]    r_state;
  logic [4:0]    r_k;
  logic [GW-1:0] r_gap;
  logic          r_cyc;
  logic [7:0]    r_addr;
  logic [3:0]    r_sel;
  logic          r_we;
  logic [31:0]   r_wdata;
  logic          r_resValid;
  logic [31:0]   r_resNonce;
  logic          r_resFound;
  logic          r_resErr;

  logic          w_timeout;
  logic          w_fail;
  logic          w_done;
  logic          w_launch;
  logic [7:0]    w_laddr;
  logic          w_lwe;
  logic [31:0]   w_ldata;

`ifdef BTC_JOB_MASTER_TIMEOUT_EN
  localparam int            TO_N    = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
  localparam int            TW      = $clog2(TO_N + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_N - 1);

  logic [TW-1:0] r_to;

  // Counts completed cycles of the outstanding transfer; cleared at launch.
  always_ff @(posedge clk) begin
    if (wbRst) begin
      r_to <= '0;
    end else if (w_launch) begin
      r_to <= '0;
    end else if (r_cyc && (r_to != TO_LAST)) begin
      r_to <= r_to + 1'b1;
    end
  end

  assign w_timeout = r_cyc && (r_to == TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // Error (or timeout) takes precedence over a simultaneous ack.
  assign w_fail = r_cyc && (wbErr || w_timeout);
  assign w_done = r_cyc && wbAck && !w_fail;

  // Next request; only issued while the bus is idle, which guarantees the
  // mandatory idle cycle after every termination.
  always_comb begin
    w_launch = 1'b0;
    w_laddr  = '0;
    w_lwe    = 1'b0;
    w_ldata  = '0;
    if (!r_cyc) begin
      case (r_state)
        S_LOAD: begin
          w_launch = jobValid;
          w_laddr  = A_HDR0 + {1'b0, r_k, 2'b00};
          w_lwe    = 1'b1;
          w_ldata  = jobWord;
        end
        S_CFG: begin
          w_launch = 1'b1;
          w_laddr  = A_CONFIG;
          w_lwe    = 1'b1;
          w_ldata  = {30'd0, cfgOneshot, cfgUseNonceIn};
        end
        S_START: begin
          w_launch = 1'b1;
          w_laddr  = A_STATUS;
          w_lwe    = 1'b1;
        end
        S_POLL: begin
          w_launch = 1'b1;
          w_laddr  = A_STATUS;
        end
        S_NONCE: begin
          w_launch = 1'b1;
          w_laddr  = A_NONCE;
        end
        default: begin
          w_launch = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wbRst) begin
      r_state    <= S_LOAD;
      r_k        <= '0;
      r_gap      <= '0;
      r_cyc      <= 1'b0;
      r_addr     <= '0;
      r_sel      <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_resValid <= 1'b0;
      r_resNonce <= '0;
      r_resFound <= 1'b0;
      r_resErr   <= 1'b0;
    end else begin
      // Bus request registers: launch and termination are mutually exclusive
      // because one needs the bus idle and the other needs it busy.
      if (w_launch) begin
        r_cyc   <= 1'b1;
        r_addr  <= w_laddr;
        r_sel   <= 4'hF;
        r_we    <= w_lwe;
        r_wdata <= w_ldata;
      end else if (w_fail || w_done) begin
        r_cyc <= 1'b0;
        r_sel <= '0;
        r_we  <= 1'b0;
      end

      if (w_fail) begin
        r_resErr   <= 1'b1;
        r_resNonce <= '0;
        r_resFound <= 1'b0;
        r_resValid <= 1'b1;
        r_state    <= S_RESULT;
      end else begin
        case (r_state)
          S_LOAD: begin
            if (w_done) begin
              if (r_k == 5'd19) begin
                r_state <= S_CFG;
              end else begin
                r_k <= r_k + 1'b1;
              end
            end
          end
          S_CFG: begin
            if (w_done) r_state <= S_START;
          end
          S_START: begin
            if (w_done) begin
              r_gap   <= GAP_LOAD;
              r_state <= S_GAP;
            end
          end
          S_GAP: begin
            if (r_gap == '0) begin
              r_state <= S_POLL;
            end else begin
              r_gap <= r_gap - 1'b1;
            end
          end
          S_POLL: begin
            if (w_done) begin
              if (wbRData[0]) begin
                r_resFound <= wbRData[1];
                r_state    <= S_NONCE;
              end else begin
                r_gap   <= GAP_LOAD;
                r_state <= S_GAP;
              end
            end
          end
          S_NONCE: begin
            if (w_done) begin
              r_resNonce <= wbRData;
              r_resErr   <= 1'b0;
              r_resValid <= 1'b1;
              r_state    <= S_RESULT;
            end
          end
          S_RESULT: begin
            if (resReady) begin
              r_resValid <= 1'b0;
              r_resNonce <= '0;
              r_resFound <= 1'b0;
              r_resErr   <= 1'b0;
              r_k        <= '0;
              r_state    <= S_LOAD;
            end
          end
          default: begin
            r_state <= S_LOAD;
          end
        endcase
      end
    end
  end

  // Consumption is tied to the acknowledge itself, never to an error.
  assign jobReady = w_done && (r_state == S_LOAD) && !wbRst;

  assign wbAddr   = r_addr;
  assign wbSel    = r_sel;
  assign wbWe     = r_we;
  assign wbWData  = r_wdata;
  assign wbCycle  = r_cyc;
  assign wbStrobe = r_cyc;
  assign resValid = r_resValid;
  assign resNonce = r_resNonce;
  assign resFound = r_resFound;
  assign resErr   = r_resErr;

endmodule

// File: tb/tb_btc_job_master.sv
module tb_btc_job_master;

  localparam int POLL_GAP = 16;

  logic        clk = 1'b0;
  logic        wbRst;
  logic [7:0]  wbAddr;
  logic [3:0]  wbSel;
  logic        wbWe;
  logic [31:0] wbWData;
  logic        wbCycle;
  logic        wbStrobe;
  logic [31:0] wbRData;
  logic        wbAck;
  logic        wbErr;
  logic [31:0] jobWord;
  logic        jobValid;
  logic        jobReady;
  logic        cfgUseNonceIn;
  logic        cfgOneshot;
  logic        resValid;
  logic        resReady;
  logic [31:0] resNonce;
  logic        resFound;
  logic        resErr;

  always #5 clk = ~clk;

  btc_job_master #(
    .POLL_GAP       (POLL_GAP),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk           (clk),
    .wbRst         (wbRst),
    .wbAddr        (wbAddr),
    .wbSel         (wbSel),
    .wbWe          (wbWe),
    .wbWData       (wbWData),
    .wbCycle       (wbCycle),
    .wbStrobe      (wbStrobe),
    .wbRData       (wbRData),
    .wbAck         (wbAck),
    .wbErr         (wbErr),
    .jobWord       (jobWord),
    .jobValid      (jobValid),
    .jobReady      (jobReady),
    .cfgUseNonceIn (cfgUseNonceIn),
    .cfgOneshot    (cfgOneshot),
    .resValid      (resValid),
    .resReady      (resReady),
    .resNonce      (resNonce),
    .resFound      (resFound),
    .resErr        (resErr)
  );

  // Job word source: word index = number of jobReady pulses since jr_mark.
  int unsigned jr_cnt  = 0;
  int unsigned jr_mark = 0;
  always @(posedge clk) if (jobReady === 1'b1) jr_cnt <= jr_cnt + 1;
  assign jobWord = 32'h1000_0000 + (jr_cnt - jr_mark);

  // Slave model: answers at the negedge after a cycle appears, logs transfers.
  typedef struct {
    logic [7:0]  a;
    logic        we;
    logic [31:0] d;
    logic [3:0]  s;
    int unsigned st;
    int unsigned en;
  } txn_t;

  txn_t        log_q[$];
  txn_t        sl_t;
  logic [31:0] stq[$];
  logic [31:0] nonce_v   = '0;
  bit          noack     = 0;
  bit          stall_en  = 0;
  bit          err_en    = 0;
  logic [7:0]  stall_addr = '0;
  logic [7:0]  err_addr   = '0;
  int unsigned ncyc = 0;
  int unsigned t_st = 0;
  bit          in_txn = 0;

  initial begin
    wbAck   = 1'b0;
    wbErr   = 1'b0;
    wbRData = '0;
  end

  always @(negedge clk) begin
    ncyc++;
    wbAck = 1'b0;
    wbErr = 1'b0;
    if (wbCycle !== 1'b1) begin
      in_txn = 0;
    end else begin
      if (!in_txn) begin
        in_txn = 1;
        t_st   = ncyc;
      end
      if (!noack && !(stall_en && wbAddr == stall_addr)) begin
        if (err_en && wbWe && wbAddr == err_addr) begin
          wbErr = 1'b1;
        end else begin
          wbAck = 1'b1;
          if (!wbWe && wbAddr == 8'h54)
            wbRData = (stq.size() > 0) ? stq.pop_front() : 32'h3;
          else if (!wbWe && wbAddr == 8'h50)
            wbRData = nonce_v;
          else
            wbRData = '0;
        end
        sl_t.a  = wbAddr;
        sl_t.we = wbWe;
        sl_t.d  = wbWData;
        sl_t.s  = wbSel;
        sl_t.st = t_st;
        sl_t.en = ncyc;
        log_q.push_back(sl_t);
      end
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_res(input int budget);
    int i;
    i = 0;
    while (resValid !== 1'b1 && i < budget) begin
      tick();
      i++;
    end
    chk("res_arrives", resValid, 1'b1);
  endtask

  initial begin
    int n;
    int hi;
    wbRst         = 1'b1;
    jobValid      = 1'b0;
    resReady      = 1'b0;
    cfgUseNonceIn = 1'b1;
    cfgOneshot    = 1'b1;
    stq           = '{32'h0, 32'h0, 32'h0, 32'h3};
    nonce_v       = 32'hDEADBEEF;
    tick();
    tick();

    // Reset state
    chk("rst_cyc",   wbCycle,  1'b0);
    chk("rst_stb",   wbStrobe, 1'b0);
    chk("rst_we",    wbWe,     1'b0);
    chk("rst_addr",  wbAddr,   8'h00);
    chk("rst_wdata", wbWData,  32'h0);
    chk("rst_sel",   wbSel,    4'h0);
    chk("rst_rdy",   jobReady, 1'b0);
    chk("rst_rv",    resValid, 1'b0);
    chk("rst_nonce", resNonce, 32'h0);
    chk("rst_found", resFound, 1'b0);
    chk("rst_err",   resErr,   1'b0);

    // Job 1: full header, three not-done polls, then done+found
    wbRst    = 1'b0;
    jobValid = 1'b1;
    wait_res(3000);
    chk("j1_ntxn", log_q.size(), 27);
    chk("j1_words", jr_cnt - jr_mark, 20);
    if (log_q.size() == 27) begin
      for (int i = 0; i < 20; i++) begin
        chk($sformatf("j1_w%0d_addr", i), log_q[i].a,  32'h4 + 4 * i);
        chk($sformatf("j1_w%0d_data", i), log_q[i].d,  32'h1000_0000 + i);
        chk($sformatf("j1_w%0d_we", i),   log_q[i].we, 1'b1);
        chk($sformatf("j1_w%0d_sel", i),  log_q[i].s,  4'hF);
      end
      chk("j1_cfg_addr",   log_q[20].a,  8'h00);
      chk("j1_cfg_data",   log_q[20].d,  32'h3);
      chk("j1_cfg_we",     log_q[20].we, 1'b1);
      chk("j1_start_addr", log_q[21].a,  8'h54);
      chk("j1_start_data", log_q[21].d,  32'h0);
      chk("j1_start_we",   log_q[21].we, 1'b1);
      for (int i = 22; i < 26; i++) begin
        chk($sformatf("j1_poll%0d_addr", i - 22), log_q[i].a,  8'h54);
        chk($sformatf("j1_poll%0d_we", i - 22),   log_q[i].we, 1'b0);
        chk($sformatf("j1_poll%0d_gap", i - 22),
            32'((log_q[i].st - log_q[i-1].en - 1) >= POLL_GAP), 1'b1);
      end
      chk("j1_nonce_addr", log_q[26].a,  8'h50);
      chk("j1_nonce_we",   log_q[26].we, 1'b0);
      for (int i = 1; i < 27; i++)
        chk($sformatf("j1_idle%0d", i), 32'((log_q[i].st - log_q[i-1].en) >= 2), 1'b1);
    end
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("j1_hold%0d_rv", c),    resValid, 1'b1);
      chk($sformatf("j1_hold%0d_nonce", c), resNonce, 32'hDEADBEEF);
      chk($sformatf("j1_hold%0d_found", c), resFound, 1'b1);
      chk($sformatf("j1_hold%0d_err", c),   resErr,   1'b0);
      chk($sformatf("j1_hold%0d_cyc", c),   wbCycle,  1'b0);
      tick();
    end

    // Prepare job 2 (STATUS 0x1: done, not found; CONFIG bits 0)
    cfgUseNonceIn = 1'b0;
    cfgOneshot    = 1'b0;
    stq           = '{32'h1};
    nonce_v       = 32'h1234_5678;
    log_q.delete();
    jr_mark       = jr_cnt;
    resReady      = 1'b1;
    tick();
    resReady      = 1'b0;
    chk("j1_rv_drop", resValid, 1'b0);
    wait_res(3000);
    chk("j2_ntxn",     log_q.size(), 24);
    chk("j2_first",    log_q[0].a,   8'h04);
    chk("j2_cfg_data", log_q[20].d,  32'h0);
    chk("j2_nonce",    resNonce,     32'h1234_5678);
    chk("j2_found",    resFound,     1'b0);
    chk("j2_err",      resErr,       1'b0);

    // Job 3: bus error on the write of word k=7 (address 0x20)
    err_en   = 1;
    err_addr = 8'h20;
    log_q.delete();
    jr_mark  = jr_cnt;
    resReady = 1'b1;
    tick();
    resReady = 1'b0;
    wait_res(500);
    chk("j3_words", jr_cnt - jr_mark, 7);
    chk("j3_ntxn",  log_q.size(), 8);
    chk("j3_eaddr", log_q[7].a, 8'h20);
    chk("j3_err",   resErr,   1'b1);
    chk("j3_nonce", resNonce, 32'h0);
    chk("j3_found", resFound, 1'b0);
    chk("j3_cyc",   wbCycle,  1'b0);
    hi = 0;
    for (int c = 0; c < 10; c++) begin
      if (wbCycle !== 1'b0) hi++;
      tick();
    end
    chk("j3_quiet", hi, 0);
    chk("j3_hold_rv", resValid, 1'b1);

    // Job 4: reset pulse while word k=10 (address 0x2C) is outstanding
    err_en     = 0;
    stall_en   = 1;
    stall_addr = 8'h2C;
    log_q.delete();
    jr_mark    = jr_cnt;
    resReady   = 1'b1;
    tick();
    resReady   = 1'b0;
    n = 0;
    while (!(wbCycle === 1'b1 && wbAddr === 8'h2C) && n < 500) begin
      tick();
      n++;
    end
    chk("j4_k10_seen", wbAddr, 8'h2C);
    wbRst = 1'b1;
    tick();
    chk("j4_rst_cyc",  wbCycle,  1'b0);
    chk("j4_rst_rv",   resValid, 1'b0);
    chk("j4_rst_addr", wbAddr,   8'h00);
    chk("j4_rst_sel",  wbSel,    4'h0);
    wbRst    = 1'b0;
    stall_en = 0;
    stq      = '{32'h3};
    nonce_v  = 32'hCAFE_F00D;
    log_q.delete();
    jr_mark  = jr_cnt;
    n = 0;
    while (log_q.size() == 0 && n < 20) begin
      tick();
      n++;
    end
    chk("j4_first_addr", log_q[0].a, 8'h04);
    chk("j4_first_data", log_q[0].d, 32'h1000_0000);
    wait_res(3000);
    chk("j4_nonce", resNonce, 32'hCAFE_F00D);
    chk("j4_found", resFound, 1'b1);
    chk("j4_err",   resErr,   1'b0);

    // Job 5: slave never responds
    noack    = 1;
    jr_mark  = jr_cnt;
    resReady = 1'b1;
    tick();
    resReady = 1'b0;
    n = 0;
    while (wbCycle !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("j5_launch", wbCycle, 1'b1);
`ifdef BTC_JOB_MASTER_TIMEOUT_EN
    n = 0;
    while (wbCycle === 1'b1 && n < 50) begin
      n++;
      tick();
    end
    chk("j5_to_len", n, 8);
    chk("j5_to_err", resErr,   1'b1);
    chk("j5_to_rv",  resValid, 1'b1);
`else
    repeat (1000) tick();
    chk("j5_wait_cyc", wbCycle,  1'b1);
    chk("j5_wait_rv",  resValid, 1'b0);
`endif
    chk("j5_no_word", jr_cnt - jr_mark, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
